// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI_mstr between two requesters, with latched requests, per-device
// chip selects and a watchdog abort. Define SPI_ARB_RR_EN for round-robin tie-breaking.
module spi_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt0,
    input  logic        wrt1,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rd_data0,
    output logic [15:0] rd_data1,
    output logic        err,
    output logic [15:0] m_cmd,
    output logic        m_wrt,
    input  logic        m_done,
    input  logic [15:0] m_rd_data,
    input  logic        m_SS_n,
    output logic        ss0_n,
    output logic        ss1_n
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, LAUNCH, ACTIVE, FINISH} state_t;

    state_t          state_reg, state_next;
    logic            owner_reg;
    logic [15:0]     m_cmd_reg;
    logic [WD_W-1:0] wd_reg;
    logic            err_reg;

    logic [1:0]      wrt_vec;
    logic [15:0]     cmd_vec [2];
    logic [1:0]      pend_vec;
    logic [15:0]     cmd_q_vec [2];
    logic [1:0]      done_vec;
    logic [15:0]     rd_vec [2];
    logic [1:0]      ss_vec;

    logic            winner;
    logic            finish_ok;
    logic            finish_to;

    assign wrt_vec    = {wrt1, wrt0};
    assign cmd_vec[0] = cmd0;
    assign cmd_vec[1] = cmd1;

`ifdef SPI_ARB_RR_EN
    logic last_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (finish_ok || finish_to) begin
            last_reg <= owner_reg;
        end
    end

    // A lone request wins outright; a tie goes to whoever was not served last.
    always_comb begin
        winner = pend_vec[1];
        if (&pend_vec) begin
            winner = ~last_reg;
        end
    end
`else
    always_comb begin
        winner = ~pend_vec[0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        finish_ok  = 1'b0;
        finish_to  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|pend_vec) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = ACTIVE;
            end
            ACTIVE: begin
                // A completion on the final watchdog cycle still counts as success.
                if (m_done) begin
                    finish_ok  = 1'b1;
                    state_next = FINISH;
                end else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    finish_to  = 1'b1;
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg <= 1'b0;
            m_cmd_reg <= '0;
            wd_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= finish_to;
            if (state_reg == IDLE && (|pend_vec)) begin
                owner_reg <= winner;
                m_cmd_reg <= cmd_q_vec[winner];
            end
            if (state_reg == LAUNCH) begin
                wd_reg <= '0;
            end else if (state_reg == ACTIVE) begin
                wd_reg <= wd_reg + WD_W'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic        pend_reg;
            logic [15:0] cmd_q_reg;
            logic        done_reg;
            logic [15:0] rd_data_reg;
            logic        clr;

            assign clr = (finish_ok || finish_to) && (owner_reg == 1'(gi));

            // A new request landing on the completion edge re-arms instead of being lost.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_reg    <= 1'b0;
                    cmd_q_reg   <= '0;
                    done_reg    <= 1'b0;
                    rd_data_reg <= '0;
                end else begin
                    done_reg <= clr;
                    if (clr) begin
                        rd_data_reg <= finish_ok ? m_rd_data : 16'hFFFF;
                    end
                    if (wrt_vec[gi] && (!pend_reg || clr)) begin
                        pend_reg  <= 1'b1;
                        cmd_q_reg <= cmd_vec[gi];
                    end else if (clr) begin
                        pend_reg <= 1'b0;
                    end
                end
            end

            assign pend_vec[gi]  = pend_reg;
            assign cmd_q_vec[gi] = cmd_q_reg;
            assign done_vec[gi]  = done_reg;
            assign rd_vec[gi]    = rd_data_reg;
            assign ss_vec[gi]    = (state_reg != IDLE && owner_reg == 1'(gi)) ? m_SS_n : 1'b1;
        end
    endgenerate

    assign m_wrt    = (state_reg == LAUNCH);
    assign m_cmd    = m_cmd_reg;
    assign err      = err_reg;
    assign done0    = done_vec[0];
    assign done1    = done_vec[1];
    assign rd_data0 = rd_vec[0];
    assign rd_data1 = rd_vec[1];
    assign ss0_n    = ss_vec[0];
    assign ss1_n    = ss_vec[1];

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: transaction-level reference model checked every cycle,
// a vector table, hand-written corner sequences and a randomized phase.
module tb_spi_arbiter;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt0 = 1'b0, wrt1 = 1'b0;
    logic [15:0] cmd0 = '0, cmd1 = '0;
    logic        done0, done1, err, m_wrt, ss0_n, ss1_n;
    logic [15:0] rd_data0, rd_data1, m_cmd;
    logic        m_done = 1'b0;
    logic [15:0] m_rd_data = '0;
    logic        m_SS_n = 1'b1;

    always #5 clk = ~clk;

    spi_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .wrt0(wrt0), .wrt1(wrt1), .cmd0(cmd0), .cmd1(cmd1),
        .done0(done0), .done1(done1), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .err(err), .m_cmd(m_cmd), .m_wrt(m_wrt), .m_done(m_done),
        .m_rd_data(m_rd_data), .m_SS_n(m_SS_n), .ss0_n(ss0_n), .ss1_n(ss1_n)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // reference model state (transaction level)
    bit          mpend [2];
    logic [15:0] mcmd [2];
    logic [15:0] mrd [2];
    bit          mlast = 1'b1;
    bit          m_idle = 1'b1;
    bit          busy = 1'b0;
    int          owner = 0;
    int          act_edge = 0;
    int          lat = 0;
    int          fin_edge = -10;
    int          master_done_edge = -1;
    logic [15:0] cur_data = '0;
    bit          rand_mode = 1'b0;
    int          next_lat = 5;
    logic [15:0] next_data = '0;

    // observation logs
    logic [15:0] launch_log[$];
    int          done_log[$];
    logic [15:0] rd_log[$];
    bit          err_log[$];

    typedef struct {
        bit          w0;
        logic [15:0] c0;
        bit          w1;
        logic [15:0] c1;
        int          lat;
        logic [15:0] data;
        int          exp_owner;
        logic [15:0] exp_cmd;
        logic [15:0] exp_rd;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input bit p0, input bit p1);
        if (p0 && p1) begin
`ifdef SPI_ARB_RR_EN
            return mlast ? 0 : 1;
`else
            return 0;
`endif
        end
        return p0 ? 0 : 1;
    endfunction

    function automatic int eff_lat();
        return (lat > TO) ? TO : lat;
    endfunction

    task automatic clear_logs();
        launch_log.delete();
        done_log.delete();
        rd_log.delete();
        err_log.delete();
    endtask

    task automatic model_reset();
        mpend[0] = 0; mpend[1] = 0;
        mrd[0] = '0; mrd[1] = '0;
        mlast = 1'b1;
        m_idle = 1'b1;
        busy = 1'b0;
        owner = 0;
        fin_edge = -10;
        master_done_edge = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_done0"}, done0, 0);
        chk({tag, "_done1"}, done1, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_m_wrt"}, m_wrt, 0);
        chk({tag, "_m_cmd"}, m_cmd, 16'h0000);
        chk({tag, "_ss0_n"}, ss0_n, 1);
        chk({tag, "_ss1_n"}, ss1_n, 1);
        chk({tag, "_rd0"}, rd_data0, 16'h0000);
        chk({tag, "_rd1"}, rd_data1, 16'h0000);
    endtask

    // One clock cycle: drive inputs, clock, then advance the model and compare every output.
    task automatic cycle(input bit w0, input logic [15:0] c0, input bit w1, input logic [15:0] c1,
                         input bit stray);
        int n;
        bit in_active, comp, launch;
        bit [1:0] prev;
        logic [15:0] data_at_edge;
        logic [15:0] exp_cmd;
        wrt0 = w0; cmd0 = c0; wrt1 = w1; cmd1 = c1;
        n = cyc + 1;
        in_active = busy && (n > act_edge) && (n <= act_edge + eff_lat());
        m_done = (n == master_done_edge) || (stray && !in_active);
        m_rd_data = cur_data;
        m_SS_n = 1'($urandom_range(0, 1));
        data_at_edge = m_rd_data;
        @(posedge clk);
        cyc = n;
        #1;
        prev = {mpend[1], mpend[0]};
        launch = m_idle && (prev != 2'b00);
        exp_cmd = '0;
        if (busy && n == fin_edge + 1) begin
            busy = 1'b0;
            m_idle = 1'b1;
        end
        comp = busy && (n == act_edge + eff_lat());
        if (launch) begin
            owner = pick(prev[0], prev[1]);
            exp_cmd = mcmd[owner];
            act_edge = n + 1;
            if (rand_mode) begin
                lat = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(1, 19);
                cur_data = 16'($urandom);
            end else begin
                lat = next_lat;
                cur_data = next_data;
            end
            master_done_edge = act_edge + lat;
            busy = 1'b1;
            m_idle = 1'b0;
        end
        if (comp) begin
            mrd[owner] = (lat <= TO) ? data_at_edge : 16'hFFFF;
            mlast = (owner == 1);
            fin_edge = n;
        end
        for (int x = 0; x < 2; x++) begin
            bit w, clr;
            logic [15:0] c;
            w = (x == 0) ? w0 : w1;
            c = (x == 0) ? c0 : c1;
            clr = comp && (owner == x);
            if (w && (!prev[x] || clr)) begin
                mpend[x] = 1'b1;
                mcmd[x] = c;
            end else if (clr) begin
                mpend[x] = 1'b0;
            end
        end

        chk("m_wrt", m_wrt, launch);
        if (launch) chk("m_cmd", m_cmd, exp_cmd);
        chk("done0", done0, comp && owner == 0);
        chk("done1", done1, comp && owner == 1);
        chk("err", err, comp && lat > TO);
        chk("rd_data0", rd_data0, mrd[0]);
        chk("rd_data1", rd_data1, mrd[1]);
        chk("ss0_n", ss0_n, (busy && owner == 0) ? m_SS_n : 1'b1);
        chk("ss1_n", ss1_n, (busy && owner == 1) ? m_SS_n : 1'b1);

        if (m_wrt) launch_log.push_back(m_cmd);
        if (done0) begin done_log.push_back(0); rd_log.push_back(rd_data0); err_log.push_back(err); end
        if (done1) begin done_log.push_back(1); rd_log.push_back(rd_data1); err_log.push_back(err); end
    endtask

    task automatic idle(input int count);
        for (int i = 0; i < count; i++) cycle(0, '0, 0, '0, 0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((busy || mpend[0] || mpend[1] || !m_idle) && guard < 300) begin
            cycle(0, '0, 0, '0, 0);
            guard++;
        end
        chk("drain_bound", guard < 300, 1);
        idle(4);
    endtask

    task automatic do_reset_mid();
        wrt0 = 0; wrt1 = 0; m_done = 0;
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        model_reset();
        @(posedge clk);
        cyc++;
        #4 rst_n = 1'b1;
    endtask

    vec_t tbl [6];
    int   exp_order [3];
    logic [15:0] exp_cmds [3];

    initial begin
        tbl[0] = '{1, 16'h1800, 0, 16'h0000, 5,    16'h0ABC, 0, 16'h1800, 16'h0ABC, 0};
        tbl[1] = '{0, 16'h0000, 1, 16'h2000, 3,    16'h1234, 1, 16'h2000, 16'h1234, 0};
        tbl[2] = '{1, 16'h1111, 1, 16'h2222, 4,    16'h5555, 0, 16'h1111, 16'h5555, 0};
        tbl[3] = '{1, 16'h3333, 0, 16'h0000, 16,   16'h7777, 0, 16'h3333, 16'h7777, 0};
        tbl[4] = '{0, 16'h0000, 1, 16'h4444, 17,   16'h8888, 1, 16'h4444, 16'hFFFF, 1};
        tbl[5] = '{1, 16'h6666, 0, 16'h0000, 1000, 16'h9999, 0, 16'h6666, 16'hFFFF, 1};

        model_reset();
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // vector table
        for (int t = 0; t < 6; t++) begin
            clear_logs();
            next_lat = tbl[t].lat;
            next_data = tbl[t].data;
            cycle(tbl[t].w0, tbl[t].c0, tbl[t].w1, tbl[t].c1, 0);
            drain();
            chk($sformatf("tbl%0d_ndone", t), done_log.size(), int'(tbl[t].w0) + int'(tbl[t].w1));
            if (launch_log.size() > 0 && done_log.size() > 0) begin
                chk($sformatf("tbl%0d_cmd", t), launch_log[0], tbl[t].exp_cmd);
                chk($sformatf("tbl%0d_owner", t), done_log[0], tbl[t].exp_owner);
                chk($sformatf("tbl%0d_rd", t), rd_log[0], tbl[t].exp_rd);
                chk($sformatf("tbl%0d_err", t), err_log[0], tbl[t].exp_err);
            end else begin
                chk($sformatf("tbl%0d_served", t), 0, 1);
            end
        end

        // tie with a re-request from requester 0 landing on its own completion edge
        do_reset_mid();
        clear_logs();
        next_lat = 8;
        next_data = 16'hBEEF;
        cycle(1, 16'h0A0A, 1, 16'h0B0B, 0);
        for (int i = 0; i < 40 && done_log.size() == 0; i++)
            cycle(busy && (cyc + 1 == act_edge + lat) && owner == 0, 16'h0C0C, 0, '0, 0);
        drain();
`ifdef SPI_ARB_RR_EN
        exp_order = '{0, 1, 0};
        exp_cmds  = '{16'h0A0A, 16'h0B0B, 16'h0C0C};
`else
        exp_order = '{0, 0, 1};
        exp_cmds  = '{16'h0A0A, 16'h0C0C, 16'h0B0B};
`endif
        chk("tie_ndone", done_log.size(), 3);
        chk("tie_nlaunch", launch_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < done_log.size()) chk($sformatf("tie_owner%0d", i), done_log[i], exp_order[i]);
            if (i < launch_log.size()) chk($sformatf("tie_cmd%0d", i), launch_log[i], exp_cmds[i]);
        end

        // duplicate request while pending is ignored
        clear_logs();
        next_lat = 6;
        cycle(0, '0, 1, 16'h2000, 0);
        cycle(0, '0, 1, 16'h3800, 0);
        drain();
        chk("dup_nlaunch", launch_log.size(), 1);
        if (launch_log.size() > 0) chk("dup_cmd", launch_log[0], 16'h2000);
        chk("dup_ndone", done_log.size(), 1);
        if (done_log.size() > 0) chk("dup_owner", done_log[0], 1);

        // timeout followed by stray completions
        clear_logs();
        next_lat = 1000;
        cycle(1, 16'h4000, 0, '0, 0);
        drain();
        for (int i = 0; i < 6; i++) cycle(0, '0, 0, '0, 1);
        chk("to_ndone", done_log.size(), 1);
        if (err_log.size() > 0) chk("to_err", err_log[0], 1);
        chk("to_rd0", rd_data0, 16'hFFFF);

        // reset mid-ACTIVE with both requests pending
        next_lat = 1000;
        cycle(1, 16'h5555, 1, 16'h6666, 0);
        idle(4);
        do_reset_mid();
        clear_logs();
        idle(10);
        chk("rst_nlaunch", launch_log.size(), 0);
        chk("rst_ndone", done_log.size(), 0);

        // randomized traffic against the model
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 7) == 0, 16'($urandom),
                  $urandom_range(0, 7) == 0, 16'($urandom),
                  $urandom_range(0, 15) == 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
